// File: rtl/qarctan_pkg.sv
// rtl/qarctan_pkg.sv - shared state encoding and quadrant constant for the arctan unit
package qarctan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        POST,
        DONE
    } state_t;

    // round(pi/4 * 2^frac_bits), derived from pi/4 held as a 32-bit fraction
    function automatic int quad1(input int frac_bits);
        logic [63:0] l_scaled;
        l_scaled = 64'd3373259426 + (64'd1 << (31 - frac_bits));
        return int'(l_scaled >> (32 - frac_bits));
    endfunction

endpackage

// File: rtl/qarctan_div.sv
// rtl/qarctan_div.sv - bit-serial unsigned restoring divider, one quotient bit per cycle
module qarctan_div #(
    parameter int DVD_W = 44,
    parameter int DVS_W = 34
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] r_rem;
    logic [DVS_W-1:0] r_dvs;
    logic [DVD_W-1:0] r_quo;
    logic [CNT_W-1:0] r_count;
    logic             r_done;

    logic [DVS_W-1:0] w_rem_src;
    logic [DVS_W-1:0] w_dvs_src;
    logic [DVD_W-1:0] w_quo_src;
    logic [DVS_W:0]   w_shift;
    logic [DVS_W+1:0] w_trial;
    logic             w_fits;
    logic [DVS_W-1:0] w_rem_next;
    logic             w_unused_bits;

    // The start cycle already performs the first step, so the final bit lands DVD_W edges after start.
    assign w_rem_src  = start ? '0 : r_rem;
    assign w_dvs_src  = start ? divisor : r_dvs;
    assign w_quo_src  = start ? dividend : r_quo;
    assign w_shift    = {w_rem_src, w_quo_src[DVD_W-1]};
    assign w_trial    = {1'b0, w_shift} - {2'b00, w_dvs_src};
    assign w_fits     = ~w_trial[DVS_W+1];
    assign w_rem_next = w_fits ? w_trial[DVS_W-1:0] : w_shift[DVS_W-1:0];
    assign w_unused_bits = w_trial[DVS_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem   <= '0;
            r_dvs   <= '0;
            r_quo   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (start) begin
            r_rem   <= w_rem_next;
            r_dvs   <= divisor;
            r_quo   <= {w_quo_src[DVD_W-2:0], w_fits};
            r_count <= CNT_W'(DVD_W - 1);
            r_done  <= 1'b0;
        end else if (r_count != '0) begin
            r_rem   <= w_rem_next;
            r_quo   <= {w_quo_src[DVD_W-2:0], w_fits};
            r_count <= r_count - CNT_W'(1);
            r_done  <= (r_count == CNT_W'(1));
        end
    end

    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/qarctan_seq.sv
// rtl/qarctan_seq.sv - sequential quadrant arctangent with valid/ready handshakes and tag sideband
module qarctan_seq
    import qarctan_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int TAG_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] y,
    input  logic        [TAG_WIDTH-1:0]  in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic        [TAG_WIDTH-1:0]  out_tag
);

    localparam int W        = DATA_WIDTH + 2;
    localparam int DIV_BITS = DATA_WIDTH + FRAC_BITS + 2;
    localparam logic signed [DIV_BITS-1:0] QUAD1 = DIV_BITS'(quad1(FRAC_BITS));
    localparam logic signed [DIV_BITS-1:0] QUAD3 = DIV_BITS'(3 * quad1(FRAC_BITS));

    state_t                         r_state;
    logic signed [DATA_WIDTH-1:0]   r_x;
    logic signed [DATA_WIDTH-1:0]   r_y;
    logic        [TAG_WIDTH-1:0]    r_tag;
    logic                           r_in_ready;
    logic                           r_out_valid;
    logic signed [DATA_WIDTH-1:0]   r_data_out;
    logic        [TAG_WIDTH-1:0]    r_out_tag;

    logic signed [W-1:0]        w_x;
    logic signed [W-1:0]        w_y;
    logic signed [W-1:0]        w_abs_y;
    logic signed [W-1:0]        w_num;
    logic signed [W-1:0]        w_den;
    logic                       w_x_neg;
    logic [W-1:0]               w_num_mag;
    logic [DIV_BITS-1:0]        w_dividend;
    logic                       w_start;
    logic                       w_div_done;
    logic [DIV_BITS-1:0]        w_quo;
    logic [W-1:0]               w_rem;
    logic signed [DIV_BITS-1:0] w_r;
    logic signed [DIV_BITS-1:0] w_base;
    logic signed [DIV_BITS-1:0] w_prod;
    logic signed [DIV_BITS-1:0] w_angle;
    logic signed [DIV_BITS-1:0] w_res;
    logic                       w_unused_bits;

    // Operands stay registered for the whole computation, so num/den/base are plain decode of them.
    assign w_x       = W'(r_x);
    assign w_y       = W'(r_y);
    assign w_x_neg   = r_x[DATA_WIDTH-1];
    assign w_abs_y   = (r_y[DATA_WIDTH-1] ? -w_y : w_y) + W'(1);
    assign w_num     = w_x_neg ? (w_x + w_abs_y) : (w_x - w_abs_y);
    assign w_den     = w_x_neg ? (w_abs_y - w_x) : (w_x + w_abs_y);
    assign w_num_mag = w_num[W-1] ? -w_num : w_num;
    assign w_dividend = {w_num_mag, {FRAC_BITS{1'b0}}};
    assign w_start   = (r_state == PREP);

    qarctan_div #(
        .DVD_W(DIV_BITS),
        .DVS_W(W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (w_start),
        .dividend (w_dividend),
        .divisor  (w_den),
        .done     (w_div_done),
        .quotient (w_quo),
        .remainder(w_rem)
    );

    // |r| never exceeds 2^FRAC_BITS, so the product and shift stay far inside DIV_BITS.
    assign w_r     = w_num[W-1] ? -$signed(w_quo) : $signed(w_quo);
    assign w_base  = w_x_neg ? QUAD3 : QUAD1;
    assign w_prod  = w_r * QUAD1;
    assign w_angle = w_base - (w_prod >>> FRAC_BITS);
    assign w_res   = r_y[DATA_WIDTH-1] ? -w_angle : w_angle;
    assign w_unused_bits = ^{w_res[DIV_BITS-1:DATA_WIDTH], w_rem};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_tag       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_out_tag   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_x        <= x;
                        r_y        <= y;
                        r_tag      <= in_tag;
                        r_in_ready <= 1'b0;
                        r_state    <= PREP;
                    end
                end
                PREP: r_state <= DIV;
                DIV: begin
                    if (w_div_done) begin
                        r_state <= POST;
                    end
                end
                POST: begin
                    r_data_out  <= w_res[DATA_WIDTH-1:0];
                    r_out_tag   <= r_tag;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_qarctan_seq.sv
// tb/tb_qarctan_seq.sv - scoreboard bench for qarctan_seq against a wide-integer reference model
module tb_qarctan_seq;

    localparam int DW       = 32;
    localparam int FB       = 10;
    localparam int TW       = 2;
    localparam int DIV_BITS = DW + FB + 2;
    localparam int LAT      = DIV_BITS + 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] x = '0;
    logic signed [DW-1:0] y = '0;
    logic [TW-1:0]        in_tag = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] data_out;
    logic [TW-1:0]        out_tag;

    qarctan_seq #(
        .DATA_WIDTH(DW),
        .FRAC_BITS (FB),
        .TAG_WIDTH (TW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint        data;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t   exp_q[$];
    int     acc_q[$];
    int     cyc = 0;
    int     last_acc = 0;
    int     n_total = 0;
    int     n_pass = 0;
    longint q1 = 804;
    bit     rand_ready = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic longint model(input longint xv, input longint yv);
        longint ay, num, den, base, r, ang;
        ay = ((yv < 0) ? -yv : yv) + 1;
        if (xv >= 0) begin
            num = xv - ay; den = xv + ay; base = q1;
        end else begin
            num = xv + ay; den = ay - xv; base = 3 * q1;
        end
        r   = (num * (64'sd1 <<< FB)) / den;
        ang = base - ((q1 * r) >>> FB);
        return (yv < 0) ? -ang : ang;
    endfunction

    task automatic send(input longint xv, input longint yv, input logic [TW-1:0] tg);
        exp_t e;
        int   budget;
        e.data = model(xv, yv);
        e.tag  = tg;
        exp_q.push_back(e);
        @(negedge clk);
        x = xv[DW-1:0];
        y = yv[DW-1:0];
        in_tag = tg;
        in_valid = 1'b1;
        budget = 0;
        while (!in_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        check("accept", in_ready, 1);
        if (!in_ready) begin
            void'(exp_q.pop_back());
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        acc_q.push_back(cyc);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 600) begin
            @(negedge clk);
            budget++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor: latency at rise, hold stability under backpressure, pop on handshake.
    bit prev_valid = 1'b0;
    bit prev_hs = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            prev_valid = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_valid && !prev_hs) check("valid_held", out_valid, 1);
            if (out_valid && !prev_valid) begin
                check("pending_expected", (exp_q.size() != 0), 1);
                if (acc_q.size() != 0) check("latency", cyc - acc_q.pop_front(), LAT);
            end
            if (out_valid && exp_q.size() != 0) begin
                if (out_ready) begin
                    e = exp_q.pop_front();
                    check("data_out", longint'(data_out), e.data);
                    check("out_tag", out_tag, e.tag);
                end else begin
                    check("hold_data", longint'(data_out), exp_q[0].data);
                    check("hold_tag", out_tag, exp_q[0].tag);
                end
            end
            prev_valid = out_valid;
            prev_hs = out_valid && out_ready;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        longint corners[6];
        longint xv, yv, a0;
        int     t, p;
        corners = '{-64'sd2147483648, 64'sd2147483647, 64'sd0, -64'sd1, 64'sd1, -64'sd2147483647};
        q1 = longint'($rtoi(3.141592653589793 / 4.0 * (2.0 ** FB) + 0.5));

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", longint'(data_out), 0);
        check("rst_out_tag", out_tag, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_in_ready_pre", in_ready, 0);
        @(posedge clk);
        #1;
        check("release_in_ready", in_ready, 1);
        out_ready = 1'b1;

        send(1024, 0, 1);                wait_drain();
        send(0, 1023, 2);                wait_drain();
        send(0, -1023, 3);               wait_drain();
        send(-1024, -1, 0);              wait_drain();
        send(0, 0, 1);                   wait_drain();
        send(corners[0], corners[0], 2); wait_drain();
        send(corners[1], corners[1], 3); wait_drain();
        send(corners[0], corners[1], 0); wait_drain();
        send(corners[1], corners[0], 1); wait_drain();

        send(700, 300, 2);
        a0 = last_acc;
        send(-300, 900, 1);
        check("throughput", last_acc - a0, DIV_BITS + 4);
        wait_drain();

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(300, -700, 2);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid", out_valid, 1);
        x = 55;
        y = 66;
        in_tag = 1;
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        p = cyc;
        send(55, 66, 1);
        check("bp_accept_cycle", last_acc, p + 2);
        wait_drain();

        send(5000, -3000, 1);
        repeat (20) @(posedge clk);
        #2;
        exp_q.delete();
        acc_q.delete();
        reset = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_data_out", longint'(data_out), 0);
        check("arst_out_tag", out_tag, 0);
        check("arst_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        check("arst_hold_in_ready", in_ready, 0);
        check("arst_hold_out_valid", out_valid, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("arst_release_in_ready", in_ready, 1);
        send(-777, 12345, 3);
        wait_drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    t = $urandom(); xv = t;
                    t = $urandom(); yv = t;
                end
                1: begin
                    xv = longint'($urandom_range(0, 4000)) - 2000;
                    yv = longint'($urandom_range(0, 4000)) - 2000;
                end
                2: begin
                    xv = corners[$urandom_range(0, 5)];
                    yv = corners[$urandom_range(0, 5)];
                end
                default: begin
                    t = $urandom(); xv = t;
                    yv = longint'($urandom_range(0, 64)) - 32;
                end
            endcase
            send(xv, yv, TW'($urandom_range(0, 3)));
        end
        @(posedge clk);
        rand_ready = 1'b0;
        #2;
        out_ready = 1'b1;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
